// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and a small window helper
// used by the timing generator and downstream pixel stages.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_VIS_DEF  = 640;
    localparam int H_FP_DEF   = 16;
    localparam int H_SYNC_DEF = 96;
    localparam int H_BP_DEF   = 48;
    localparam int V_VIS_DEF  = 480;
    localparam int V_FP_DEF   = 10;
    localparam int V_SYNC_DEF = 2;
    localparam int V_BP_DEF   = 33;

    localparam int H_TOT = H_VIS_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOT = V_VIS_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Half-open window test lo <= v < hi on counter-width values.
    function automatic logic in_window(
        input logic [CNT_W-1:0] v,
        input logic [CNT_W-1:0] lo,
        input logic [CNT_W-1:0] hi
    );
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with enable; exposes the registered count, its next value
// and a terminal-count flag so the next stage can chain and pre-compute outputs.
module mod_counter #(
    parameter int W   = 10,
    parameter int MOD = 800
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_next,
    output logic         tc
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);
    localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ZERO = {W{1'b0}};

    logic [W-1:0] count_r;
    logic [W-1:0] count_next_s;

    // Next value wraps at LAST, so no value >= MOD is ever reachable.
    always_comb begin
        count_next_s = count_r;
        if (en) begin
            if (count_r == LAST) begin
                count_next_s = ZERO;
            end else begin
                count_next_s = count_r + ONE;
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= ZERO;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count      = count_r;
    assign count_next = count_next_s;
    assign tc         = (count_r == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: half-rate pixel enable, X/Y counters and registered
// hs/vs/blank/frame_tick aligned with DrawX/DrawY.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VIS  = H_VIS_DEF,
    parameter int H_FP   = H_FP_DEF,
    parameter int H_SYNC = H_SYNC_DEF,
    parameter int H_BP   = H_BP_DEF,
    parameter int V_VIS  = V_VIS_DEF,
    parameter int V_FP   = V_FP_DEF,
    parameter int V_SYNC = V_SYNC_DEF,
    parameter int V_BP   = V_BP_DEF
) (
    input  logic             Clk,
    input  logic             Reset_n,
    output logic             pixel_en,
    output logic             hs,
    output logic             vs,
    output logic             blank,
    output logic [CNT_W-1:0] DrawX,
    output logic [CNT_W-1:0] DrawY,
    output logic             frame_tick
);

    localparam int L_H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int L_V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_VIS_W  = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VIS + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VIS + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_VIS_W  = CNT_W'(V_VIS);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VIS + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VIS + V_FP + V_SYNC);

    logic             pixel_en_r;
    logic             hs_r;
    logic             vs_r;
    logic             blank_r;
    logic             frame_tick_r;
    logic [CNT_W-1:0] x_s;
    logic [CNT_W-1:0] y_s;
    logic [CNT_W-1:0] x_next_s;
    logic [CNT_W-1:0] y_next_s;
    logic             h_tc_s;
    logic             v_en_s;
    logic             v_tc_unused_s;

    assign v_en_s = pixel_en_r & h_tc_s;

    mod_counter #(
        .W   (CNT_W),
        .MOD (L_H_TOT)
    ) u_h_cnt (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .en         (pixel_en_r),
        .count      (x_s),
        .count_next (x_next_s),
        .tc         (h_tc_s)
    );

    mod_counter #(
        .W   (CNT_W),
        .MOD (L_V_TOT)
    ) u_v_cnt (
        .clk        (Clk),
        .rst_n      (Reset_n),
        .en         (v_en_s),
        .count      (y_s),
        .count_next (y_next_s),
        .tc         (v_tc_unused_s)
    );

    // Outputs are decoded from next-count values so they land with DrawX/DrawY.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_en_r   <= 1'b0;
            hs_r         <= 1'b1;
            vs_r         <= 1'b1;
            blank_r      <= 1'b0;
            frame_tick_r <= 1'b0;
        end else begin
            pixel_en_r   <= ~pixel_en_r;
            hs_r         <= ~in_window(x_next_s, HS_START, HS_END);
            vs_r         <= ~in_window(y_next_s, VS_START, VS_END);
            blank_r      <= (x_next_s < H_VIS_W) && (y_next_s < V_VIS_W);
            frame_tick_r <= v_en_s && (y_next_s == V_VIS_W);
        end
    end

    assign pixel_en   = pixel_en_r;
    assign hs         = hs_r;
    assign vs         = vs_r;
    assign blank      = blank_r;
    assign frame_tick = frame_tick_r;
    assign DrawX      = x_s;
    assign DrawY      = y_s;

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_VIS, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- Clk, in, 1, single system clock (50 MHz)
- Reset_n, in, 1, asynchronous active-low reset
- pixel_en, out, 1, pixel-rate enable, high every second Clk cycle
- hs, out, 1, horizontal sync, active-low
- vs, out, 1, vertical sync, active-low
- blank, out, 1, high inside the visible region, low in porches/sync
- DrawX, out, 10, current horizontal pixel count
- DrawY, out, 10, current line count
- frame_tick, out, 1, one-Clk pulse at the start of vertical blanking
REQ-003 The design SHALL use one clock and an asynchronous, active-low reset; no other clock or reset SHALL exist.

Function
REQ-004 pixel_en SHALL toggle every Clk cycle, giving a 25 MHz pixel rate; all counters SHALL advance only in cycles where pixel_en=1.
REQ-005 Line length is H_TOT = H_VIS+H_FP+H_SYNC+H_BP (800); frame height is V_TOT = V_VIS+V_FP+V_SYNC+V_BP (525).
REQ-006 DrawX SHALL count 0..H_TOT-1 and wrap to 0; on that wrap, DrawY SHALL increment.
REQ-007 DrawY SHALL count 0..V_TOT-1; at (H_TOT-1, V_TOT-1) an advance SHALL take both counters to (0,0) in the same cycle.
REQ-008 hs SHALL be 0 exactly when H_VIS+H_FP <= DrawX < H_VIS+H_FP+H_SYNC (656..751), and 1 otherwise.
REQ-009 vs SHALL be 0 exactly when V_VIS+V_FP <= DrawY < V_VIS+V_FP+V_SYNC (490..491), and 1 otherwise.
REQ-010 blank SHALL be 1 exactly when DrawX < H_VIS and DrawY < V_VIS.
REQ-011 hs, vs and blank SHALL be registered outputs, computed from next-count values so they align with DrawX/DrawY in the same Clk cycle; they SHALL have zero relative skew and no combinational path from counters to outputs.
REQ-012 frame_tick SHALL be 1 for exactly one Clk cycle: the cycle in which the counters first read (0, V_VIS). It SHALL be 0 at all other times, including after reset.
REQ-013 Counter arithmetic SHALL be 10-bit unsigned; the wrap comparisons in REQ-006/007 SHALL prevent any value >= H_TOT or V_TOT from being reachable.
REQ-014 DrawX/DrawY SHALL be held (not advanced) during cycles where pixel_en=0.

Reset
REQ-015 While Reset_n=0 (asserted at any time, including mid-frame), the outputs SHALL be: DrawX=0, DrawY=0, pixel_en=0, hs=1, vs=1, blank=0, frame_tick=0.
REQ-016 On release of Reset_n: the first rising Clk edge SHALL set pixel_en=1; counting SHALL restart from (0,0); blank SHALL become 1 in that same cycle.

Structure
REQ-017 A shared package vga_pkg SHALL hold the default timing constants and the derived H_TOT/V_TOT localparams, so that the color mapper and game-logic stages share them.
REQ-018 One sub-module SHALL be instantiated twice (horizontal and vertical): mod_counter, a parameterised wrap counter with enable and terminal-count output.

Verification
REQ-019 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Reset then run 1 line -> DrawX steps 0..799 every 2 Clk; hs low for exactly 96 pixel periods starting at DrawX=656; 1600 Clk per line.
- Run 1 full frame -> DrawY wraps 524->0; vs low for exactly 2 lines at DrawY 490..491; 840000 Clk per frame.
- Run 3 frames -> frame_tick exactly 3 pulses, each 1 Clk wide, each at (0,480), spaced 840000 Clk apart.
- Corner check -> at (639,479) blank=1; at (640,479) blank=0; at (0,480) blank=0.
- Assert Reset_n at (400,300) for 3 Clk -> all outputs take their REQ-015 values immediately (asynchronous); after release, counting restarts from (0,0).
- Override parameters to H_VIS=8, all H porches/sync=2, V_VIS=4 -> counters wrap at 13 and the V total; sync windows move accordingly.
